// File: rtl/m72_pkg.sv
// m72_pkg: shared types for the M72 SDRAM CPU channel
package m72_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_CPU, ARB_BUSY_SND} sdr_arb_state_t;
  typedef struct packed {
    logic [23:0] addr;
    logic        we;
    logic [1:0]  be;
    logic [15:0] wdata;
  } sdr_cycle_t;
  function automatic logic [15:0] merge_be(input logic [15:0] old, input logic [15:0] wd, input logic [1:0] be);
    return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
  endfunction
endpackage

// File: rtl/cpu_sdr_arbiter_port.sv
// sdr_req_port: per-CPU cycle capture, wait-state generation, local completion and one-entry read cache
module sdr_req_port
  import m72_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [23:0] addr,
  input  logic        we,
  input  logic [1:0]  be,
  input  logic [15:0] wdata,
  input  logic        writable,
  output logic [15:0] rdata,
  output logic        ready,
  output sdr_cycle_t  cyc,
  output logic        pend,
  input  logic        done,
  input  logic        tmo,
  input  logic [15:0] done_data,
  input  logic        inv,
  input  logic [23:0] inv_addr
);
  logic req_q, pend_q, pend_d, chk_q, chk_d, wr_q, wr_d, cv_q, cv_d;
  sdr_cycle_t cyc_q, cyc_d;
  logic [23:0] ca_q, ca_d;
  logic [15:0] cd_q, cd_d, rdata_q, rdata_d;
  logic cap, hit, own_match, local_done, complete;
  // chk_q marks the single cycle after capture in which a local completion is decided
  always_comb begin
    own_match = ca_q == cyc_q.addr;
    hit = CACHE_EN & cv_q & ~cyc_q.we & own_match;
    local_done = chk_q & (hit | (cyc_q.we & (~wr_q | cyc_q.be == 2'b00)));
    complete = local_done | done;
    cap = req & ~req_q & (~pend_q | complete);
    pend_d = cap | (pend_q & ~complete);
    chk_d = cap;
    cyc_d = cap ? {addr, we, be, wdata} : cyc_q;
    wr_d = cap ? writable : wr_q;
    rdata_d = cyc_q.we ? rdata_q : local_done ? cd_q : done ? done_data : rdata_q;
    cv_d = cv_q;
    ca_d = ca_q;
    cd_d = cd_q;
    if (done & ~cyc_q.we & ~tmo) begin
      cv_d = 1'b1;
      ca_d = cyc_q.addr;
      cd_d = done_data;
    end else if (done & tmo & (~cyc_q.we | own_match))
      cv_d = 1'b0;
    else if (done & cyc_q.we & own_match)
      cd_d = merge_be(cd_q, cyc_q.wdata, cyc_q.be);
    if (inv & ca_q == inv_addr) cv_d = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      pend_q  <= 1'b0;
      chk_q   <= 1'b0;
      wr_q    <= 1'b0;
      cyc_q   <= '0;
      rdata_q <= '0;
      cv_q    <= 1'b0;
      ca_q    <= '0;
      cd_q    <= '0;
    end else begin
      req_q   <= req;
      pend_q  <= pend_d;
      chk_q   <= chk_d;
      wr_q    <= wr_d;
      cyc_q   <= cyc_d;
      rdata_q <= rdata_d;
      cv_q    <= cv_d;
      ca_q    <= ca_d;
      cd_q    <= cd_d;
    end
  end
  assign rdata = rdata_q;
  assign ready = ~pend_q;
  assign cyc   = cyc_q;
  assign pend  = pend_q & ~local_done;
endmodule

// File: rtl/cpu_sdr_arbiter.sv
// cpu_sdr_arbiter: round-robin sharing of one SDRAM channel between the V30 CPU and the sound Z80
module cpu_sdr_arbiter
  import m72_pkg::*;
#(
  parameter int TIMEOUT  = 256,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        CLK_32M,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [23:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_be,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_writable,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        snd_req,
  input  logic [23:0] snd_addr,
  input  logic        snd_we,
  input  logic [1:0]  snd_be,
  input  logic [15:0] snd_wdata,
  input  logic        snd_writable,
  output logic [15:0] snd_rdata,
  output logic        snd_ready,
  output logic        sdr_req,
  output logic [23:0] sdr_addr,
  output logic        sdr_we,
  output logic [1:0]  sdr_be,
  output logic [15:0] sdr_wdata,
  input  logic [15:0] sdr_rdata,
  input  logic        sdr_ack,
  output logic        sdr_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  sdr_arb_state_t state_q, state_d;
  logic last_q, last_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  sdr_cycle_t sdr_q, sdr_d, cpu_cyc, snd_cyc;
  logic cpu_pend, snd_pend, cpu_done, snd_done, grant, pick_snd, tmo, fin;
  logic [15:0] done_data;
  sdr_req_port #(.CACHE_EN(CACHE_EN)) u_cpu (
    .clk(CLK_32M), .rst(reset), .req(cpu_req), .addr(cpu_addr), .we(cpu_we), .be(cpu_be),
    .wdata(cpu_wdata), .writable(cpu_writable), .rdata(cpu_rdata), .ready(cpu_ready),
    .cyc(cpu_cyc), .pend(cpu_pend), .done(cpu_done), .tmo(tmo), .done_data(done_data),
    .inv(snd_done & snd_cyc.we), .inv_addr(snd_cyc.addr)
  );
  sdr_req_port #(.CACHE_EN(CACHE_EN)) u_snd (
    .clk(CLK_32M), .rst(reset), .req(snd_req), .addr(snd_addr), .we(snd_we), .be(snd_be),
    .wdata(snd_wdata), .writable(snd_writable), .rdata(snd_rdata), .ready(snd_ready),
    .cyc(snd_cyc), .pend(snd_pend), .done(snd_done), .tmo(tmo), .done_data(done_data),
    .inv(cpu_done & cpu_cyc.we), .inv_addr(cpu_cyc.addr)
  );
  // last_q = 1 means SND held the bus last, so CPU wins the next tie
  always_comb begin
    tmo = state_q != ARB_IDLE & ~sdr_ack & cnt_q == CW'(TIMEOUT - 1);
    fin = state_q != ARB_IDLE & (sdr_ack | tmo);
    cpu_done = fin & state_q == ARB_BUSY_CPU;
    snd_done = fin & state_q == ARB_BUSY_SND;
    done_data = sdr_ack ? sdr_rdata : 16'hFFFF;
    grant = state_q == ARB_IDLE & (cpu_pend | snd_pend);
    pick_snd = snd_pend & (~cpu_pend | ~last_q);
    state_d = grant ? (pick_snd ? ARB_BUSY_SND : ARB_BUSY_CPU) : fin ? ARB_IDLE : state_q;
    last_d = grant ? pick_snd : last_q;
    cnt_d = (state_q == ARB_IDLE | fin) ? '0 : cnt_q + CW'(1);
    sdr_d = grant ? (pick_snd ? snd_cyc : cpu_cyc) : sdr_q;
    err_d = err_q | tmo;
  end
  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      sdr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      sdr_q   <= sdr_d;
      err_q   <= err_d;
    end
  end
  assign sdr_req   = state_q != ARB_IDLE;
  assign sdr_addr  = sdr_q.addr;
  assign sdr_we    = sdr_q.we;
  assign sdr_be    = sdr_q.be;
  assign sdr_wdata = sdr_q.wdata;
  assign sdr_err   = err_q;
endmodule

// File: tb/tb_cpu_sdr_arbiter.sv
// tb_cpu_sdr_arbiter: directed and randomized checks of the CPU/sound SDRAM arbiter
module tb_cpu_sdr_arbiter;
  localparam int TMO = 256;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] req = '0, we = '0, wr = '0;
  logic [1:0][23:0] addr = '0;
  logic [1:0][1:0] be = '0;
  logic [1:0][15:0] wd = '0;
  wire [15:0] cpu_rdata, snd_rdata, sdr_wdata;
  wire cpu_ready, snd_ready, sdr_req, sdr_we, sdr_err;
  wire [23:0] sdr_addr;
  wire [1:0] sdr_be;
  logic [15:0] sdr_rdata;
  logic resp_ack, man_ack = 1'b0;
  wire sdr_ack = resp_ack | man_ack;
  wire [1:0] rdy = {snd_ready, cpu_ready};
  wire [1:0][15:0] rdv = {snd_rdata, cpu_rdata};

  cpu_sdr_arbiter #(.TIMEOUT(TMO), .CACHE_EN(1'b1)) dut (
    .CLK_32M(clk), .reset(reset),
    .cpu_req(req[0]), .cpu_addr(addr[0]), .cpu_we(we[0]), .cpu_be(be[0]), .cpu_wdata(wd[0]),
    .cpu_writable(wr[0]), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .snd_req(req[1]), .snd_addr(addr[1]), .snd_we(we[1]), .snd_be(be[1]), .snd_wdata(wd[1]),
    .snd_writable(wr[1]), .snd_rdata(snd_rdata), .snd_ready(snd_ready),
    .sdr_req(sdr_req), .sdr_addr(sdr_addr), .sdr_we(sdr_we), .sdr_be(sdr_be), .sdr_wdata(sdr_wdata),
    .sdr_rdata(sdr_rdata), .sdr_ack(sdr_ack), .sdr_err(sdr_err)
  );

  function automatic logic [15:0] f(input logic [23:0] a);
    return a[15:0] ^ 16'h5A3C ^ {a[23:16], a[23:16]};
  endfunction
  function automatic logic [15:0] bmerge(input logic [15:0] o, input logic [15:0] d, input logic [1:0] b);
    logic [15:0] r;
    r = o;
    if (b[1]) r[15:8] = d[15:8];
    if (b[0]) r[7:0] = d[7:0];
    return r;
  endfunction

  // SDRAM side: memory that really receives writes, answering after ack_delay cycles
  logic [15:0] smem [int];
  logic [15:0] rmem [int];
  int ack_delay = 1;
  logic resp_en = 1'b1, ovr_en = 1'b0;
  logic [15:0] ovr_data = '0;
  function automatic logic [15:0] smem_rd(input logic [23:0] a);
    return smem.exists(int'(a)) ? smem[int'(a)] : f(a);
  endfunction
  function automatic logic [15:0] rmem_rd(input logic [23:0] a);
    return rmem.exists(int'(a)) ? rmem[int'(a)] : f(a);
  endfunction
  initial begin
    int cnt;
    cnt = 0;
    resp_ack = 1'b0;
    sdr_rdata = '0;
    forever begin
      @(negedge clk);
      if (resp_ack) begin
        resp_ack = 1'b0;
        cnt = 0;
      end else if (sdr_req && resp_en) begin
        cnt++;
        if (cnt >= ack_delay) begin
          resp_ack = 1'b1;
          cnt = 0;
          if (sdr_we) smem[int'(sdr_addr)] = bmerge(smem_rd(sdr_addr), sdr_wdata, sdr_be);
          else sdr_rdata = ovr_en ? ovr_data : smem_rd(sdr_addr);
        end
      end else cnt = 0;
    end
  end

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // lat: edges after the capture edge until ready is seen high; rk: first such edge with sdr_req high
  task automatic do_txn(input int p, input logic [23:0] a, input logic w, input logic [1:0] b,
                        input logic [15:0] d, input logic wrt, output int lat, output int rk,
                        output logic [15:0] rd);
    @(negedge clk);
    addr[p] = a; we[p] = w; be[p] = b; wd[p] = d; wr[p] = wrt; req[p] = 1'b1;
    lat = -1;
    rk = -1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (sdr_req && rk < 0) rk = k;
      if (rdy[p]) begin
        lat = k;
        break;
      end
    end
    rd = rdv[p];
    @(negedge clk);
    req[p] = 1'b0;
  endtask

  task automatic both(input logic [23:0] a0, input logic [23:0] a1, output logic [23:0] first, output int ok);
    @(negedge clk);
    addr[0] = a0; addr[1] = a1; we = '0; be = '1; wr = '1; req = 2'b11;
    first = '0;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (k == 1) first = sdr_addr;
      if (k > 0 && rdy == 2'b11) begin
        ok = 1;
        break;
      end
    end
    @(negedge clk);
    req = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int lat, rk, ok;
    logic [15:0] rd, t;
    logic [23:0] first, a;
    logic [23:0] aset [4];
    logic cv [2];
    logic [23:0] ca [2];
    logic w, wrt, exp_sdr;
    logic [1:0] b;
    logic [15:0] d, exp_rd;
    int p;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_ready", cpu_ready, 1);
    chk("rst_snd_ready", snd_ready, 1);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_snd_rdata", snd_rdata, 0);
    chk("rst_sdr_req", sdr_req, 0);
    chk("rst_sdr_addr", sdr_addr, 0);
    chk("rst_sdr_err", sdr_err, 0);
    @(negedge clk);
    reset = 1'b0;

    ack_delay = 5; ovr_en = 1'b1; ovr_data = 16'hBEEF;
    do_txn(0, 24'h001234, 1'b0, 2'b11, 16'h0, 1'b1, lat, rk, rd);
    chk("rd_req_edge", rk, 1);
    chk("rd_lat", lat, 6);
    chk("rd_data", rd, 16'hBEEF);
    ovr_en = 1'b0;
    do_txn(0, 24'h001234, 1'b0, 2'b11, 16'h0, 1'b1, lat, rk, rd);
    chk("hit_no_req", rk, -1);
    chk("hit_lat", lat, 1);
    chk("hit_data", rd, 16'hBEEF);

    do_reset();
    ack_delay = 2;
    both(24'h000100, 24'h000200, first, ok);
    chk("rr1_done", ok, 1);
    chk("rr1_first", first, 24'h000100);
    chk("rr1_cpu_data", cpu_rdata, f(24'h000100));
    chk("rr1_snd_data", snd_rdata, f(24'h000200));
    do_txn(0, 24'h000300, 1'b0, 2'b11, 16'h0, 1'b1, lat, rk, rd);
    chk("solo_lat", lat, 3);
    both(24'h000400, 24'h000500, first, ok);
    chk("rr2_done", ok, 1);
    chk("rr2_first", first, 24'h000500);

    do_txn(0, 24'h000500, 1'b1, 2'b10, 16'h5500, 1'b1, lat, rk, rd);
    rmem[int'(24'h000500)] = bmerge(rmem_rd(24'h000500), 16'h5500, 2'b10);
    chk("wr_req_edge", rk, 1);
    chk("wr_lat", lat, 3);
    t = f(24'h000500);
    do_txn(1, 24'h000500, 1'b0, 2'b11, 16'h0, 1'b1, lat, rk, rd);
    chk("inv_snd_req", rk, 1);
    chk("inv_snd_data", rd, {8'h55, t[7:0]});
    do_txn(1, 24'h000500, 1'b0, 2'b11, 16'h0, 1'b1, lat, rk, rd);
    chk("refill_hit_lat", lat, 1);
    chk("refill_hit_data", rd, {8'h55, t[7:0]});
    do_txn(0, 24'h800400, 1'b0, 2'b11, 16'h0, 1'b1, lat, rk, rd);
    chk("addr24_req", rk, 1);
    chk("addr24_data", rd, f(24'h800400));

    do_txn(0, 24'h000700, 1'b1, 2'b11, 16'h1234, 1'b0, lat, rk, rd);
    chk("ro_no_req", rk, -1);
    chk("ro_lat", lat, 1);
    do_txn(1, 24'h000700, 1'b1, 2'b00, 16'h1234, 1'b1, lat, rk, rd);
    chk("be0_no_req", rk, -1);
    chk("be0_lat", lat, 1);

    resp_en = 1'b0;
    do_txn(0, 24'h000900, 1'b0, 2'b11, 16'h0, 1'b1, lat, rk, rd);
    chk("tmo_req_edge", rk, 1);
    chk("tmo_lat", lat, 1 + TMO);
    chk("tmo_data", rd, 16'hFFFF);
    chk("tmo_err", sdr_err, 1);
    resp_en = 1'b1;
    do_txn(0, 24'h000900, 1'b0, 2'b11, 16'h0, 1'b1, lat, rk, rd);
    chk("tmo_inval_req", rk, 1);
    chk("tmo_inval_data", rd, f(24'h000900));
    chk("err_sticky", sdr_err, 1);

    resp_en = 1'b0;
    @(negedge clk);
    addr[0] = 24'h000A00; we[0] = 1'b0; be[0] = 2'b11; wr[0] = 1'b1; req[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_req", sdr_req, 1);
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    @(posedge clk); #1;
    chk("rstb_sdr_req", sdr_req, 0);
    chk("rstb_cpu_ready", cpu_ready, 1);
    chk("rstb_cpu_rdata", cpu_rdata, 0);
    chk("rstb_sdr_addr", sdr_addr, 0);
    chk("rstb_sdr_err", sdr_err, 0);
    @(negedge clk);
    reset = 1'b0;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    resp_en = 1'b1;
    @(posedge clk); #1;
    chk("late_ack_req", sdr_req, 0);
    chk("late_ack_ready", cpu_ready, 1);
    chk("late_ack_rdata", cpu_rdata, 0);

    do_reset();
    aset[0] = 24'h000010; aset[1] = 24'h800010; aset[2] = 24'h000011; aset[3] = 24'h012345;
    cv[0] = 1'b0; cv[1] = 1'b0; ca[0] = '0; ca[1] = '0;
    for (int n = 0; n < 80; n++) begin
      p = int'($urandom_range(0, 1));
      a = aset[$urandom_range(0, 3)];
      w = ($urandom_range(0, 2) == 0);
      b = 2'($urandom_range(0, 3));
      wrt = ($urandom_range(0, 3) != 0);
      d = 16'($urandom);
      ack_delay = int'($urandom_range(1, 4));
      exp_rd = '0;
      if (w) begin
        exp_sdr = wrt && b != 2'b00;
        if (exp_sdr) begin
          rmem[int'(a)] = bmerge(rmem_rd(a), d, b);
          if (ca[1-p] == a) cv[1-p] = 1'b0;
        end
      end else begin
        exp_sdr = !(cv[p] && ca[p] == a);
        cv[p] = 1'b1;
        ca[p] = a;
        exp_rd = rmem_rd(a);
      end
      do_txn(p, a, w, b, d, wrt, lat, rk, rd);
      chk("rnd_req_edge", rk, exp_sdr ? 1 : -1);
      chk("rnd_lat", lat, exp_sdr ? 1 + ack_delay : 1);
      if (!w) chk("rnd_rdata", rd, exp_rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
